// File: rtl/pulse_stretcher_multi_pkg.sv
// rtl/pulse_stretcher_multi_pkg.sv - shared mode constants for the multi-channel pulse stretcher
package pulse_stretcher_multi_pkg;

    localparam logic MODE_LEAD  = 1'b0;
    localparam logic MODE_TRAIL = 1'b1;

endpackage

// File: rtl/pulse_stretcher_multi_if.sv
// rtl/pulse_stretcher_multi_if.sv - channel inputs, shared controls and stretched outputs
interface pulse_stretcher_multi_if #(
    parameter int CHANNELS = 4,
    parameter int BITS     = 20
);
    logic [CHANNELS-1:0] in;
    logic [BITS-1:0]     hold;
    logic [CHANNELS-1:0] mode;
    logic                retrigger;
    logic [CHANNELS-1:0] out;
    logic [CHANNELS-1:0] stretching;

    modport master (
        output in, hold, mode, retrigger,
        input  out, stretching
    );

    modport slave (
        input  in, hold, mode, retrigger,
        output out, stretching
    );
endinterface

// File: rtl/pulse_stretcher_multi_stretch_channel.sv
// rtl/pulse_stretcher_multi_stretch_channel.sv - one channel: edge detect, hold counter, registered output
module stretch_channel
    import pulse_stretcher_multi_pkg::*;
#(
    parameter int BITS = 20
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            i_in,
    input  logic [BITS-1:0] i_hold,
    input  logic            i_mode,
    input  logic            i_retrigger,
    output logic            o_out,
    output logic            o_stretching
);
    logic            r_prev_in;
    logic [BITS-1:0] r_cnt;
    logic            r_out;
    logic            r_stretching;

    logic            w_rise;
    logic            w_fall;
    logic            w_cnt_zero;
    logic [BITS-1:0] w_reload;
    logic [BITS-1:0] w_cnt_nxt;
    logic            w_out_nxt;

    assign w_rise     = i_in & ~r_prev_in;
    assign w_fall     = ~i_in & r_prev_in;
    assign w_cnt_zero = (r_cnt == '0);
    // The load cycle itself is the first held cycle, hence hold-1.
    assign w_reload   = (i_hold == '0) ? '0 : (i_hold - BITS'(1));

    always_comb begin
        w_cnt_nxt = r_cnt;
        w_out_nxt = 1'b0;
        if (i_mode == MODE_LEAD) begin
            if (w_rise && (w_cnt_zero || i_retrigger)) begin
                w_out_nxt = 1'b1;
                w_cnt_nxt = w_reload;
            end else if (!w_cnt_zero) begin
                w_out_nxt = 1'b1;
                w_cnt_nxt = r_cnt - BITS'(1);
            end else begin
                w_out_nxt = i_in;
            end
        end else begin
            if (w_fall) begin
                w_out_nxt = (i_hold != '0);
                w_cnt_nxt = w_reload;
            end else if (i_in) begin
                w_out_nxt = 1'b1;
                w_cnt_nxt = '0;
            end else if (!w_cnt_zero) begin
                w_out_nxt = 1'b1;
                w_cnt_nxt = r_cnt - BITS'(1);
            end else begin
                w_out_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev_in    <= 1'b0;
            r_cnt        <= '0;
            r_out        <= 1'b0;
            r_stretching <= 1'b0;
        end else begin
            r_prev_in    <= i_in;
            r_cnt        <= w_cnt_nxt;
            r_out        <= w_out_nxt;
            r_stretching <= (w_cnt_nxt != '0);
        end
    end

    assign o_out        = r_out;
    assign o_stretching = r_stretching;
endmodule

// File: rtl/pulse_stretcher_multi.sv
// rtl/pulse_stretcher_multi.sv - CHANNELS independent stretchers sharing hold and retrigger
module pulse_stretcher_multi
    import pulse_stretcher_multi_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int BITS     = 20
) (
    input  logic                    clk,
    input  logic                    reset_n,
    pulse_stretcher_multi_if.slave  bus
);
    logic [CHANNELS-1:0] w_out;
    logic [CHANNELS-1:0] w_stretching;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        stretch_channel #(
            .BITS(BITS)
        ) u_ch (
            .clk          (clk),
            .reset_n      (reset_n),
            .i_in         (bus.in[g]),
            .i_hold       (bus.hold),
            .i_mode       (bus.mode[g]),
            .i_retrigger  (bus.retrigger),
            .o_out        (w_out[g]),
            .o_stretching (w_stretching[g])
        );
    end

    assign bus.out        = w_out;
    assign bus.stretching = w_stretching;
endmodule

// File: tb/tb_pulse_stretcher_multi.sv
// tb/tb_pulse_stretcher_multi.sv - table-driven scoreboard bench for pulse_stretcher_multi
module tb_pulse_stretcher_multi;
    localparam int CH = 4;
    localparam int BW = 20;

    typedef struct {
        logic [CH-1:0] in;
        logic [BW-1:0] hold;
        logic [CH-1:0] mode;
        logic          retrig;
        logic [CH-1:0] eout;
        logic [CH-1:0] estr;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    vec_t tbl_main[$];
    vec_t tbl_post[$];
    logic [2*CH-1:0] sb[$];

    pulse_stretcher_multi_if #(.CHANNELS(CH), .BITS(BW)) bus ();

    pulse_stretcher_multi #(.CHANNELS(CH), .BITS(BW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic [CH-1:0] in, input int hold, input logic [CH-1:0] mode,
                                input logic retrig, input logic [CH-1:0] eout, input logic [CH-1:0] estr);
        vec_t v;
        v.in = in; v.hold = BW'(hold); v.mode = mode; v.retrig = retrig;
        v.eout = eout; v.estr = estr;
        return v;
    endfunction

    task automatic check_now(input string name, input logic [CH-1:0] eout, input logic [CH-1:0] estr);
        checks++;
        if (bus.out !== eout || bus.stretching !== estr) begin
            errors++;
            $display("FAIL %s: out=%b stretching=%b, expected out=%b stretching=%b",
                     name, bus.out, bus.stretching, eout, estr);
        end
    endtask

    task automatic apply(input string name, input int idx, input vec_t v);
        logic [2*CH-1:0] exp;
        @(negedge clk);
        bus.in = v.in; bus.hold = v.hold; bus.mode = v.mode; bus.retrigger = v.retrig;
        sb.push_back({v.eout, v.estr});
        @(posedge clk);
        #1;
        exp = sb.pop_front();
        checks++;
        if (bus.out !== exp[2*CH-1:CH] || bus.stretching !== exp[CH-1:0]) begin
            errors++;
            $display("FAIL %s[%0d]: out=%b stretching=%b, expected out=%b stretching=%b",
                     name, idx, bus.out, bus.stretching, exp[2*CH-1:CH], exp[CH-1:0]);
        end
    endtask

    initial begin
        logic [CH-1:0] prev_in;
        logic [CH-1:0] rnd;

        // Reset release with all inputs high, then idle.
        tbl_main.push_back(mk(4'hF, 0, 4'h0, 0, 4'hF, 4'h0));
        tbl_main.push_back(mk(4'h0, 0, 4'h0, 0, 4'h0, 4'h0));
        // LEAD H=5, one-cycle pulse.
        tbl_main.push_back(mk(4'h1, 5, 4'h0, 0, 4'h1, 4'h1));
        for (int i = 0; i < 3; i++) tbl_main.push_back(mk(4'h0, 5, 4'h0, 0, 4'h1, 4'h1));
        tbl_main.push_back(mk(4'h0, 5, 4'h0, 0, 4'h1, 4'h0));
        tbl_main.push_back(mk(4'h0, 5, 4'h0, 0, 4'h0, 4'h0));
        // LEAD H=5, nine-cycle pulse outlasts the hold.
        for (int i = 0; i < 4; i++) tbl_main.push_back(mk(4'h1, 5, 4'h0, 0, 4'h1, 4'h1));
        for (int i = 0; i < 5; i++) tbl_main.push_back(mk(4'h1, 5, 4'h0, 0, 4'h1, 4'h0));
        tbl_main.push_back(mk(4'h0, 5, 4'h0, 0, 4'h0, 4'h0));
        // LEAD H=4, pulses at t and t+2, retrigger on.
        tbl_main.push_back(mk(4'h1, 4, 4'h0, 1, 4'h1, 4'h1));
        tbl_main.push_back(mk(4'h0, 4, 4'h0, 1, 4'h1, 4'h1));
        tbl_main.push_back(mk(4'h1, 4, 4'h0, 1, 4'h1, 4'h1));
        tbl_main.push_back(mk(4'h0, 4, 4'h0, 1, 4'h1, 4'h1));
        tbl_main.push_back(mk(4'h0, 4, 4'h0, 1, 4'h1, 4'h1));
        tbl_main.push_back(mk(4'h0, 4, 4'h0, 1, 4'h1, 4'h0));
        tbl_main.push_back(mk(4'h0, 4, 4'h0, 1, 4'h0, 4'h0));
        // Same pulses, retrigger off.
        tbl_main.push_back(mk(4'h1, 4, 4'h0, 0, 4'h1, 4'h1));
        tbl_main.push_back(mk(4'h0, 4, 4'h0, 0, 4'h1, 4'h1));
        tbl_main.push_back(mk(4'h1, 4, 4'h0, 0, 4'h1, 4'h1));
        tbl_main.push_back(mk(4'h0, 4, 4'h0, 0, 4'h1, 4'h0));
        tbl_main.push_back(mk(4'h0, 4, 4'h0, 0, 4'h0, 4'h0));
        // TRAIL H=3, input high three cycles.
        for (int i = 0; i < 3; i++) tbl_main.push_back(mk(4'h1, 3, 4'h1, 0, 4'h1, 4'h0));
        tbl_main.push_back(mk(4'h0, 3, 4'h1, 0, 4'h1, 4'h1));
        tbl_main.push_back(mk(4'h0, 3, 4'h1, 0, 4'h1, 4'h1));
        tbl_main.push_back(mk(4'h0, 3, 4'h1, 0, 4'h1, 4'h0));
        tbl_main.push_back(mk(4'h0, 3, 4'h1, 0, 4'h0, 4'h0));
        // TRAIL re-pulse at t+4 cancels the tail, new tail follows.
        for (int i = 0; i < 3; i++) tbl_main.push_back(mk(4'h1, 3, 4'h1, 0, 4'h1, 4'h0));
        tbl_main.push_back(mk(4'h0, 3, 4'h1, 0, 4'h1, 4'h1));
        tbl_main.push_back(mk(4'h1, 3, 4'h1, 0, 4'h1, 4'h0));
        tbl_main.push_back(mk(4'h0, 3, 4'h1, 0, 4'h1, 4'h1));
        tbl_main.push_back(mk(4'h0, 3, 4'h1, 0, 4'h1, 4'h1));
        tbl_main.push_back(mk(4'h0, 3, 4'h1, 0, 4'h1, 4'h0));
        tbl_main.push_back(mk(4'h0, 3, 4'h1, 0, 4'h0, 4'h0));
        // Mixed modes; hold drops to 2 while ch0/ch2 run a 6-cycle stretch.
        tbl_main.push_back(mk(4'h7, 6, 4'hA, 0, 4'h7, 4'h5));
        tbl_main.push_back(mk(4'h0, 2, 4'hA, 0, 4'h7, 4'h7));
        tbl_main.push_back(mk(4'h0, 2, 4'hA, 0, 4'h7, 4'h5));
        tbl_main.push_back(mk(4'h0, 2, 4'hA, 0, 4'h5, 4'h5));
        tbl_main.push_back(mk(4'h0, 2, 4'hA, 0, 4'h5, 4'h5));
        tbl_main.push_back(mk(4'h0, 2, 4'hA, 0, 4'h5, 4'h0));
        tbl_main.push_back(mk(4'h0, 2, 4'hA, 0, 4'h0, 4'h0));
        // Start stretches on ch0 (LEAD) and ch3 (TRAIL) before a mid-stretch reset.
        tbl_main.push_back(mk(4'h9, 5, 4'hA, 0, 4'h9, 4'h1));
        tbl_main.push_back(mk(4'h0, 5, 4'hA, 0, 4'h9, 4'h9));
        // After reset: no residual tail.
        for (int i = 0; i < 3; i++) tbl_post.push_back(mk(4'h0, 5, 4'hA, 0, 4'h0, 4'h0));

        bus.in = '1; bus.hold = '0; bus.mode = '0; bus.retrigger = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_now("reset_hold", 4'h0, 4'h0);

        @(negedge clk);
        reset_n = 1'b1;
        foreach (tbl_main[i]) apply("main", i, tbl_main[i]);

        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_now("async_reset", 4'h0, 4'h0);
        @(posedge clk);
        #1;
        check_now("reset_held", 4'h0, 4'h0);
        @(negedge clk);
        bus.in = '0;
        reset_n = 1'b1;
        foreach (tbl_post[i]) apply("post_reset", i, tbl_post[i]);

        // hold = 0: out is in delayed one cycle in both modes.
        prev_in = '0;
        for (int i = 0; i < 40; i++) begin
            vec_t v;
            rnd = CH'($urandom_range(0, 15));
            v = mk(rnd, 0, 4'h6, i[0], rnd, 4'h0);
            apply("hold0", i, v);
            prev_in = rnd;
        end
        checks++;
        if (prev_in !== bus.out) begin
            errors++;
            $display("FAIL hold0_final: out=%b, expected %b", bus.out, prev_in);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
